// File: rtl/ysyx_22050039_mdu.sv
`default_nettype none
// ysyx_22050039_mdu: iterative RV64 M-extension unit, radix-2 shift-add multiplier and restoring divider.
// Revision: 1.0
module ysyx_22050039_mdu #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_err
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
    return XLEN'($signed(v << (XLEN - 32)) >>> (XLEN - 32));
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [XLEN-1:0] v);
    return v & ({XLEN{1'b1}} >> (XLEN - 32));
  endfunction

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] acc_q, opa_q, opb_q, res_q;
  logic            w_q, raw_q, rem_q, negq_q, negr_q, err_q, valid_q, oerr_q;

  logic [2:0]      base;
  logic            op_w, op_sgn, op_mul, op_rem, op_legal;
  logic            neg1, neg2, div0, ovf, special;
  logic [XLEN-1:0] ext1, ext2, mag1, mag2, min_neg, spec_res;
  logic [XLEN:0]   shifted, trial;
  logic [XLEN-1:0] quo, remv, fin;

  always_comb begin
    base     = in_op[2:0];
    op_w     = in_op[3];
    op_legal = (base <= 3'd4) && (!op_w || (XLEN == 64));
    op_sgn   = (base == 3'd1) || (base == 3'd3);
    op_mul   = (base == 3'd0);
    op_rem   = (base == 3'd3) || (base == 3'd4);
    ext1     = op_w ? (op_sgn ? sext32(in_src1) : zext32(in_src1)) : in_src1;
    ext2     = op_w ? (op_sgn ? sext32(in_src2) : zext32(in_src2)) : in_src2;
    neg1     = op_sgn && ext1[XLEN-1];
    neg2     = op_sgn && ext2[XLEN-1];
    mag1     = neg1 ? -ext1 : ext1;
    mag2     = neg2 ? -ext2 : ext2;
    min_neg  = op_w ? ({XLEN{1'b1}} << 31) : ({XLEN{1'b1}} << (XLEN - 1));
    div0     = (ext2 == '0);
    ovf      = op_sgn && (ext1 == min_neg) && (ext2 == '1);
    special  = !op_legal || (!op_mul && (div0 || ovf));
    spec_res = '0;
    if (op_legal) begin
      if (div0)     spec_res = op_rem ? ext1 : '1;
      else if (ovf) spec_res = op_rem ? '0 : ext1;
    end
  end

  // Restoring step: bring in the next dividend bit, keep the difference only if it did not borrow.
  always_comb begin
    shifted = {acc_q, opa_q[XLEN-1]};
    trial   = shifted - {1'b0, opb_q};
    quo     = negq_q ? -opa_q : opa_q;
    remv    = negr_q ? -acc_q : acc_q;
    fin     = raw_q ? acc_q : (rem_q ? remv : quo);
    if (w_q) fin = sext32(fin);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid) state_d = special ? S_DONE : (op_mul ? S_MUL : S_DIV);
      S_MUL,
      S_DIV:  if (cnt_q == '0) state_d = S_DONE;
      S_DONE: if (valid_q && out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      w_q     <= 1'b0;
      raw_q   <= 1'b0;
      rem_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      oerr_q  <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          cnt_q  <= op_w ? CW'(31) : CW'(XLEN - 1);
          w_q    <= op_w;
          raw_q  <= op_mul || special;
          rem_q  <= op_rem;
          negq_q <= neg1 ^ neg2;
          negr_q <= neg1;
          err_q  <= !op_legal;
          // Special cases park their answer in acc_q and pass straight through DONE.
          if (special) begin
            acc_q <= spec_res;
            opa_q <= '0;
            opb_q <= '0;
          end else if (op_mul) begin
            acc_q <= '0;
            opa_q <= ext1;
            opb_q <= ext2;
          end else begin
            acc_q <= '0;
            opa_q <= op_w ? (mag1 << (XLEN - 32)) : mag1;
            opb_q <= mag2;
          end
        end
        S_MUL: begin
          if (opb_q[0]) acc_q <= acc_q + opa_q;
          opa_q <= opa_q << 1;
          opb_q <= opb_q >> 1;
          cnt_q <= cnt_q - CW'(1);
        end
        S_DIV: begin
          acc_q <= trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
          opa_q <= {opa_q[XLEN-2:0], ~trial[XLEN]};
          cnt_q <= cnt_q - CW'(1);
        end
        S_DONE: begin
          if (!valid_q) begin
            res_q   <= fin;
            oerr_q  <= err_q;
            valid_q <= 1'b1;
          end else if (out_ready) begin
            valid_q <= 1'b0;
          end
        end
        default: valid_q <= 1'b0;
      endcase
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = valid_q;
  assign out_result = res_q;
  assign out_err    = oerr_q;

endmodule
`default_nettype wire
